// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the iterative integer divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);
    localparam int MAX_WIDTH = 64;

    // Wide enough for any supported WIDTH; users truncate to their width.
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/alu_div_if.sv
// ============================================================================
// Module      : alu_div_if
// Description : Decode-to-divider operand/result bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             stall_req;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  stall_req, result_valid, quotient, remainder
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output stall_req, result_valid, quotient, remainder
    );

endinterface : alu_div_if

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    // The shifted remainder needs one extra bit before comparison; the
    // difference itself always fits in WIDTH bits because it is < divisor.
    assign shifted   = {rem, quo[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, divisor});
    assign diff      = shifted[WIDTH-1:0] - divisor;

    assign rem_next  = no_borrow ? diff : shifted[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], no_borrow};

endmodule : div_step

`default_nettype wire

// File: rtl/alu_div.sv
// ============================================================================
// Module      : alu_div
// Description : Iterative signed/unsigned divider producing LO/HI with stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      resetn,
    alu_div_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] Q_DIV0 = DIV0_QUOTIENT[WIDTH-1:0];

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             valid_r;

    logic             accept;
    logic             step;
    logic             last_step;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign accept    = (state == IDLE) && bus.start && !bus.cancel;
    assign step      = (state == BUSY) && !bus.cancel;
    assign last_step = step && (count == '0);

    assign a_neg = bus.is_signed && bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed && bus.divisor[WIDTH-1];
    assign a_abs = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs = b_neg ? -bus.divisor  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY: begin
                if (bus.cancel)        state_nxt = IDLE;
                else if (count == '0)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div0        <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            valid_r     <= 1'b0;
        end else begin
            valid_r <= last_step;
            if (accept) begin
                count <= CW'(WIDTH - 1);
                rem   <= '0;
                quo   <= a_abs;
                dvsr  <= b_abs;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                div0  <= (bus.divisor == '0);
            end else if (step) begin
                count <= count - 1'b1;
                rem   <= rem_nxt;
                quo   <= quo_nxt;
            end
            // Divide-by-zero: the remainder path already yields the original
            // dividend, only the quotient needs forcing to all ones.
            if (last_step) begin
                quotient_r  <= div0  ? Q_DIV0   : (neg_q ? -quo_nxt : quo_nxt);
                remainder_r <= neg_r ? -rem_nxt : rem_nxt;
            end
        end
    end

    assign bus.stall_req    = resetn && (accept || step);
    assign bus.result_valid = valid_r;
    assign bus.quotient     = quotient_r;
    assign bus.remainder    = remainder_r;

endmodule : alu_div

`default_nettype wire
